// File: rtl/level_monitor.sv
// level_monitor
//
// Watches the level output of a saturating up/down counter. Every clock
// edge it compares the new sample with the previous one and turns the
// transition into an event:
//   1 UP       level rose by exactly one
//   2 DN       level fell by exactly one
//   3 JUMP     level moved by two or more (MAX<->0 is a jump, not a wrap)
//   4 SAT_TOP  level has sat at MAX for SAT_HOLD consecutive samples
//   5 SAT_BOT  level has sat at 0 for SAT_HOLD consecutive samples
// Events go into a small FIFO that is drained through a valid/ready port.
//
// Ports:
//   clk       clock, all state changes on the rising edge
//   reset     synchronous active-high reset
//   level     observed counter level, sampled every edge
//   ev_valid  FIFO head holds an event
//   ev_ready  consumer takes the head event on this edge
//   ev_code   event code of the head (0 while empty)
//   ev_level  level sample that produced the head event (0 while empty)
//   sat_top   level held at MAX for at least SAT_HOLD samples
//   sat_bot   level held at 0 for at least SAT_HOLD samples
//   step_cnt  UP+DN events seen (queued or dropped), wraps at 256
//   overflow  sticky, an event was dropped on a full FIFO

module level_monitor #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int SAT_HOLD = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] level,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [2:0]       ev_code,
    output logic [WIDTH-1:0] ev_level,
    output logic             sat_top,
    output logic             sat_bot,
    output logic [7:0]       step_cnt,
    output logic             overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(SAT_HOLD + 1);

    localparam logic [WIDTH-1:0] LVL_MAX  = '1;
    localparam logic [WIDTH-1:0] LVL_MIN  = '0;
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [HW-1:0]    HOLD_SAT = HW'(SAT_HOLD);
    localparam logic [HW-1:0]    HOLD_ONE = HW'(1);

    localparam logic signed [WIDTH:0] D_P1 = (WIDTH+1)'(1);
    localparam logic signed [WIDTH:0] D_M1 = (WIDTH+1)'(-1);

    localparam logic [2:0] EV_NONE    = 3'd0;
    localparam logic [2:0] EV_UP      = 3'd1;
    localparam logic [2:0] EV_DN      = 3'd2;
    localparam logic [2:0] EV_JUMP    = 3'd3;
    localparam logic [2:0] EV_SAT_TOP = 3'd4;
    localparam logic [2:0] EV_SAT_BOT = 3'd5;

    logic [WIDTH-1:0]        prev_level;
    logic                    prev_valid;
    logic [HW-1:0]           hold_cnt;

    logic [2:0]              mem_code  [DEPTH];
    logic [WIDTH-1:0]        mem_level [DEPTH];
    logic [PW-1:0]           wr_ptr;
    logic [PW-1:0]           rd_ptr;
    logic [CW-1:0]           count;

    logic signed [WIDTH:0]   delta;
    logic                    at_top;
    logic                    at_bot;
    logic [HW-1:0]           hold_nxt;
    logic                    sat_hit;
    logic [2:0]              new_code;
    logic                    push;
    logic                    pop;
    logic                    accept;
    logic                    drop;
    logic                    is_step;

    always_comb begin
        delta    = $signed({1'b0, level}) - $signed({1'b0, prev_level});
        at_top   = (level == LVL_MAX);
        at_bot   = (level == LVL_MIN);
        hold_nxt = '0;
        sat_hit  = 1'b0;
        new_code = EV_NONE;

        if (!prev_valid) begin
            // First sample after reset only primes the history.
            hold_nxt = (at_top || at_bot) ? HOLD_ONE : '0;
        end else if ((at_top || at_bot) && (level == prev_level)) begin
            hold_nxt = (hold_cnt == HOLD_SAT) ? HOLD_SAT : hold_cnt + 1'b1;
        end else if (at_top || at_bot) begin
            hold_nxt = HOLD_ONE;
        end

        // Saturation fires only on the edge the hold count first reaches
        // SAT_HOLD; afterwards the count is pinned there and stays quiet.
        sat_hit = prev_valid && (hold_cnt != HOLD_SAT) && (hold_nxt == HOLD_SAT);

        if (prev_valid) begin
            if (delta == D_P1) begin
                new_code = EV_UP;
            end else if (delta == D_M1) begin
                new_code = EV_DN;
            end else if (delta != '0) begin
                new_code = EV_JUMP;
            end else if (sat_hit) begin
                new_code = at_top ? EV_SAT_TOP : EV_SAT_BOT;
            end
        end

        push    = (new_code != EV_NONE);
        pop     = (count != '0) && ev_ready;
        // A full FIFO still takes the new event when the head leaves on the same edge.
        accept  = push && ((count != CNT_FULL) || pop);
        drop    = push && !accept;
        is_step = (new_code == EV_UP) || (new_code == EV_DN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_level <= '0;
            prev_valid <= 1'b0;
            hold_cnt   <= '0;
            sat_top    <= 1'b0;
            sat_bot    <= 1'b0;
            step_cnt   <= '0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            prev_level <= level;
            prev_valid <= 1'b1;
            hold_cnt   <= hold_nxt;

            if (prev_valid) begin
                if (sat_hit && at_top) begin
                    sat_top <= 1'b1;
                end else if (!at_top) begin
                    sat_top <= 1'b0;
                end
                if (sat_hit && at_bot) begin
                    sat_bot <= 1'b1;
                end else if (!at_bot) begin
                    sat_bot <= 1'b0;
                end
            end

            if (is_step) begin
                step_cnt <= step_cnt + 8'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end

            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem_code[wr_ptr]  <= new_code;
            mem_level[wr_ptr] <= level;
        end
    end

    always_comb begin
        ev_valid = (count != '0);
        ev_code  = ev_valid ? mem_code[rd_ptr]  : 3'd0;
        ev_level = ev_valid ? mem_level[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_level_monitor.sv
module tb_level_monitor;

    localparam logic [2:0] UP = 3'd1, DN = 3'd2, JMP = 3'd3, STOP = 3'd4, SBOT = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] level;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_code;
    logic [1:0] ev_level;
    logic       sat_top;
    logic       sat_bot;
    logic [7:0] step_cnt;
    logic       overflow;

    typedef struct packed {
        logic [2:0] code;
        logic [1:0] lvl;
    } ev_t;

    ev_t exp_q[$];
    ev_t head;
    int  checks = 0;
    int  passes = 0;

    level_monitor #(.WIDTH(2), .DEPTH(4), .SAT_HOLD(3)) dut (
        .clk(clk), .reset(reset), .level(level),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_level(ev_level),
        .sat_top(sat_top), .sat_bot(sat_bot), .step_cnt(step_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: compares the DUT head against the scoreboard on the falling edge.
    always @(negedge clk) begin
        if (!reset && ev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event_code", int'(ev_code), 0);
            end else if (ev_ready) begin
                head = exp_q.pop_front();
                chk("pop_code", int'(ev_code), int'(head.code));
                chk("pop_level", int'(ev_level), int'(head.lvl));
            end else begin
                chk("stall_code", int'(ev_code), int'(exp_q[0].code));
                chk("stall_level", int'(ev_level), int'(exp_q[0].lvl));
            end
        end
    end

    // Apply one level sample; code 0 means no event is expected to be queued.
    task automatic drive(input logic [1:0] lv, input logic [2:0] code);
        level = lv;
        if (code != 3'd0) exp_q.push_back(ev_t'{code: code, lvl: lv});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_remaining", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        level    = 2'd0;
        ev_ready = 1'b1;
        do_reset();
        chk("rst_ev_valid", ev_valid, 0);
        chk("rst_ev_code", ev_code, 0);
        chk("rst_ev_level", ev_level, 0);
        chk("rst_sat_top", sat_top, 0);
        chk("rst_sat_bot", sat_bot, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_overflow", overflow, 0);

        // Ramp up, saturate at top, jump down, saturate at bottom, step out.
        drive(2'd0, 3'd0);
        drive(2'd1, UP);
        drive(2'd2, UP);
        drive(2'd3, UP);
        chk("ramp_step_cnt", step_cnt, 3);
        chk("ramp_sat_top", sat_top, 0);
        drive(2'd3, 3'd0);
        chk("hold2_sat_top", sat_top, 0);
        drive(2'd3, STOP);
        chk("hold3_sat_top", sat_top, 1);
        drive(2'd3, 3'd0);
        drive(2'd0, JMP);
        chk("jump_sat_top", sat_top, 0);
        chk("jump_step_cnt", step_cnt, 3);
        drive(2'd0, 3'd0);
        chk("bot_hold2_sat_bot", sat_bot, 0);
        drive(2'd0, SBOT);
        chk("bot_hold3_sat_bot", sat_bot, 1);
        drive(2'd0, 3'd0);
        drive(2'd1, UP);
        chk("leave_bot_sat_bot", sat_bot, 0);
        chk("leave_bot_step_cnt", step_cnt, 4);
        drive(2'd1, 3'd0);
        drive(2'd1, 3'd0);
        drive(2'd1, 3'd0);
        chk("idle_ev_valid", ev_valid, 0);

        // Stalled consumer: four events fill the FIFO, two are dropped.
        do_reset();
        ev_ready = 1'b0;
        drive(2'd1, 3'd0);
        drive(2'd2, UP);
        drive(2'd1, DN);
        drive(2'd2, UP);
        drive(2'd1, DN);
        chk("full_overflow_before", overflow, 0);
        chk("full_ev_valid", ev_valid, 1);
        drive(2'd2, 3'd0);
        chk("drop_overflow", overflow, 1);
        drive(2'd1, 3'd0);
        chk("drop_step_cnt", step_cnt, 6);
        ev_ready = 1'b1;
        wait_drain();
        chk("drained_ev_valid", ev_valid, 0);
        chk("drained_overflow_sticky", overflow, 1);

        // Reset with two events pending.
        ev_ready = 1'b0;
        drive(2'd2, UP);
        drive(2'd1, DN);
        chk("pending_ev_valid", ev_valid, 1);
        do_reset();
        chk("midrst_ev_valid", ev_valid, 0);
        chk("midrst_step_cnt", step_cnt, 0);
        chk("midrst_overflow", overflow, 0);
        ev_ready = 1'b1;
        drive(2'd3, 3'd0);
        drive(2'd3, 3'd0);
        chk("first_sample_ev_valid", ev_valid, 0);
        chk("first_sample_step_cnt", step_cnt, 0);

        // Full FIFO with a pop on the same edge as a new UP.
        do_reset();
        drive(2'd1, 3'd0);
        ev_ready = 1'b0;
        drive(2'd2, UP);
        drive(2'd1, DN);
        drive(2'd2, UP);
        drive(2'd1, DN);
        chk("full2_ev_valid", ev_valid, 1);
        ev_ready = 1'b1;
        drive(2'd2, UP);
        chk("pop_push_overflow", overflow, 0);
        wait_drain();
        chk("pop_push_overflow_end", overflow, 0);
        chk("pop_push_step_cnt", step_cnt, 5);
        chk("pop_push_ev_valid", ev_valid, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
